// File: rtl/coldata_i2c_pkg.sv
// -----------------------------------------------------------------------------
// coldata_i2c_pkg
// Shared types and constants for the COLDATA serial-control engine.
//   state_t    : engine FSM states
//   MODE_XFER  : mode value for a frame transfer
//   MODE_MEAS  : mode value for a round-trip latency measurement
//   frame_bits : bits in one frame (8 data + 1 ack per byte)
// -----------------------------------------------------------------------------
package coldata_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_TAIL  = 3'd2,
        ST_MEAS  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_XFER = 1'b0;
    localparam logic MODE_MEAS = 1'b1;

    function automatic int frame_bits(input int n_bytes);
        return n_bytes * 9;
    endfunction

endpackage

// File: rtl/coldata_i2c_lat_chan.sv
// -----------------------------------------------------------------------------
// coldata_i2c_lat_chan
// Per-link latency measurement and latency-compensated readback sampling.
// Ports:
//   clk62p5    in   system clock
//   rst        in   asynchronous active-high reset
//   en_i       in   link takes part in the current operation
//   meas_go_i  in   one-cycle pulse on the cycle the probe low is driven (T0)
//   strb_i     in   main bit strobe from the frame shifter
//   sda_in_i   in   data returned from the link
//   lat_o      out  measured round-trip latency in cycles
//   lat_err_o  out  last measurement saw no returning low
//   rd_o       out  sampled readback frame, MSB first
// -----------------------------------------------------------------------------
module coldata_i2c_lat_chan #(
    parameter int MAX_LAT    = 31,
    parameter int LAT_W      = 5,
    parameter int FRAME_BITS = 27
) (
    input  logic                  clk62p5,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  meas_go_i,
    input  logic                  strb_i,
    input  logic                  sda_in_i,
    output logic [LAT_W-1:0]      lat_o,
    output logic                  lat_err_o,
    output logic [FRAME_BITS-1:0] rd_o
);

    logic [LAT_W-1:0]      k_q;
    logic                  active_q;
    logic [LAT_W-1:0]      lat_q;
    logic                  err_q;
    logic [MAX_LAT-1:0]    dly_q;
    logic [FRAME_BITS-1:0] rd_q;
    logic [MAX_LAT:0]      line_d;
    logic                  tap_d;

    // line_d[k] is the main strobe delayed by k cycles; entry 0 is the live
    // strobe so a zero-latency link samples on the strobe cycle itself.
    assign line_d = {dly_q, strb_i};
    assign tap_d  = line_d[lat_q];

    always_ff @(posedge clk62p5 or posedge rst) begin
        if (rst) begin
            k_q      <= '0;
            active_q <= 1'b0;
            lat_q    <= '0;
            err_q    <= 1'b0;
            dly_q    <= '0;
            rd_q     <= '0;
        end else begin
            dly_q <= line_d[MAX_LAT-1:0];

            if (en_i && tap_d) begin
                rd_q <= {rd_q[FRAME_BITS-2:0], sda_in_i};
            end

            if (meas_go_i && en_i) begin
                k_q      <= LAT_W'(1);
                active_q <= 1'b1;
            end else if (active_q) begin
                if (!sda_in_i) begin
                    lat_q    <= k_q;
                    err_q    <= 1'b0;
                    active_q <= 1'b0;
                end else if (k_q == LAT_W'(MAX_LAT)) begin
                    // Window exhausted: flag the timeout, keep the old latency.
                    err_q    <= 1'b1;
                    active_q <= 1'b0;
                end
                // Saturate rather than wrap so a late low can never alias.
                if (k_q != LAT_W'(MAX_LAT)) begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    assign lat_o     = lat_q;
    assign lat_err_o = err_q;
    assign rd_o      = rd_q;

endmodule

// File: rtl/coldata_i2c_mc.sv
// -----------------------------------------------------------------------------
// coldata_i2c_mc
// Multi-channel COLDATA serial-control engine. Shifts one frame out to every
// enabled FEMB link at once, measures per-link cable round-trip latency and
// samples the returned bits with that latency compensated.
// Ports:
//   clk62p5   in   system clock
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle request, honoured only when idle
//   mode      in   0 = frame transfer, 1 = latency measurement
//   ch_mask   in   per-link enable, captured at start
//   wr_frame  in   frame to send, MSB first, captured at start
//   busy      out  engine active (cycle after start through done)
//   done      out  one-cycle completion pulse
//   rd_frame  out  per-link sampled frames, link 0 in the LSBs
//   lat       out  per-link measured latency
//   lat_err   out  per-link timeout flag of the last measurement
//   scl       out  per-link serial clock
//   sda_out   out  per-link serial data
//   sda_in    in   per-link returned data
// -----------------------------------------------------------------------------
module coldata_i2c_mc
    import coldata_i2c_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int N_BYTES = 3,
    parameter int CLK_DIV = 4,
    parameter int MAX_LAT = 31,
    localparam int FB     = frame_bits(N_BYTES),
    localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
    input  logic                  clk62p5,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [FB-1:0]         wr_frame,
    output logic                  busy,
    output logic                  done,
    output logic [N_CH*FB-1:0]    rd_frame,
    output logic [N_CH*LAT_W-1:0] lat,
    output logic [N_CH-1:0]       lat_err,
    output logic [N_CH-1:0]       scl,
    output logic [N_CH-1:0]       sda_out,
    input  logic [N_CH-1:0]       sda_in
);

    localparam int BIT_W = $clog2(FB);
    localparam int PH_W  = $clog2(2 * CLK_DIV);

    state_t            state_q;
    logic [PH_W-1:0]   ph_q;
    logic [BIT_W-1:0]  bit_q;
    logic [LAT_W-1:0]  cnt_q;
    logic [N_CH-1:0]   mask_q;
    logic [FB-2:0]     sh_q;
    logic [N_CH-1:0]   scl_q;
    logic [N_CH-1:0]   sda_q;
    logic              busy_q;
    logic              done_q;

    logic              bit_end_d;
    logic              strb_d;
    logic              meas_go_d;
    logic              win_end_d;

    assign bit_end_d = (ph_q == PH_W'(2 * CLK_DIV - 1));
    assign strb_d    = (state_q == ST_SHIFT) && bit_end_d;
    assign meas_go_d = (state_q == ST_MEAS) && (cnt_q == '0);
    assign win_end_d = (cnt_q == LAT_W'(MAX_LAT));

    // scl/sda are registered one cycle ahead of the bit they belong to, so
    // each transition computes the value for the following cycle. Masked
    // links are OR-ed high everywhere they are loaded.
    always_ff @(posedge clk62p5 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            sh_q    <= '0;
            scl_q   <= '1;
            sda_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mask_q <= ch_mask;
                        busy_q <= 1'b1;
                        ph_q   <= '0;
                        cnt_q  <= '0;
                        bit_q  <= BIT_W'(FB - 1);
                        case (mode)
                            MODE_XFER: begin
                                state_q <= ST_SHIFT;
                                sh_q    <= wr_frame[FB-2:0];
                                scl_q   <= ~ch_mask;
                                sda_q   <= ~ch_mask | {N_CH{wr_frame[FB-1]}};
                            end
                            MODE_MEAS: begin
                                // Probe low lasts exactly the first MEAS cycle.
                                state_q <= ST_MEAS;
                                sda_q   <= ~ch_mask;
                            end
                        endcase
                    end
                end

                ST_SHIFT: begin
                    if (bit_end_d) begin
                        ph_q <= '0;
                        if (bit_q == '0) begin
                            state_q <= ST_TAIL;
                            scl_q   <= '1;
                            sda_q   <= '1;
                        end else begin
                            bit_q <= bit_q - 1'b1;
                            sh_q  <= {sh_q[FB-3:0], 1'b0};
                            scl_q <= ~mask_q;
                            sda_q <= ~mask_q | {N_CH{sh_q[FB-2]}};
                        end
                    end else begin
                        ph_q <= ph_q + 1'b1;
                        if (ph_q == PH_W'(CLK_DIV - 1)) begin
                            scl_q <= '1;
                        end
                    end
                end

                // Wait out the longest delayed strobe before reporting done.
                ST_TAIL: begin
                    if (win_end_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_MEAS: begin
                    sda_q <= '1;
                    if (win_end_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        coldata_i2c_lat_chan #(
            .MAX_LAT    (MAX_LAT),
            .LAT_W      (LAT_W),
            .FRAME_BITS (FB)
        ) u_chan (
            .clk62p5   (clk62p5),
            .rst       (rst),
            .en_i      (mask_q[c]),
            .meas_go_i (meas_go_d),
            .strb_i    (strb_d),
            .sda_in_i  (sda_in[c]),
            .lat_o     (lat[c*LAT_W +: LAT_W]),
            .lat_err_o (lat_err[c]),
            .rd_o      (rd_frame[c*FB +: FB])
        );
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign scl     = scl_q;
    assign sda_out = sda_q;

endmodule
